ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the transmit counterpart of the PS/2 keyboard receive path in the top level.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard using the standard host request-to-send sequence. Checks the device ACK and reports completion or error.
- Drives the open-drain PS/2 lines through active-high pull-low enables.
- Shares ps2_clock/ps2_data with the receiver; the top level gates the receiver off while busy=1.

Parameters:
- INHIBIT_CYCLES, 10000: clk_in cycles the PS/2 clock is held low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk_in cycles between consecutive device clock falling edges, including the wait for the first edge (15 ms).

Ports:
- clk_in  in  1  system clock, 100 MHz.
- reset_btn  in  1  asynchronous reset, active-high.
- tx_data  in  8  byte to send; sampled on the accept cycle.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid && tx_ready.
- ps2_clk_i  in  1  raw PS/2 clock line (asynchronous).
- ps2_data_i  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull the PS/2 clock line low; 0 = release.
- ps2_data_oe  out  1  1 = pull the PS/2 data line low; 0 = release.
- busy  out  1  high from the accept cycle until the return to IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and ACK received.
- tx_error  out  1  one-cycle pulse: transfer failed.
- err_code  out  2  valid with tx_error and held until the next accept: 01 = timeout, 10 = no ACK.

Behaviour:
- Reset (asynchronous): state IDLE; ps2_clk_oe=0, ps2_data_oe=0; busy=0; tx_ready=1; tx_done=0; tx_error=0; err_code=00. Counters and the shift register are cleared.
- Input synchronisation: ps2_clk_i and ps2_data_i each pass through 2 flops.
- A falling edge (fe) is a synced clock 1 in the previous cycle and 0 in this cycle. fe is acted on one cycle after it is detected.
- Accept: latch {parity, tx_data} into a 9-bit shift register; parity = ~^tx_data (odd parity). Set busy=1 and go to INHIBIT. tx_valid is ignored while busy.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: clk_oe=1, data_oe=1 for exactly 1 cycle (start-bit setup), then go to XFER.
- XFER: clk_oe=0. data_oe starts at 1 (start bit = 0). Edge counter n runs 0..11.
  - On fe n=1..8: data_oe = ~tx_data[n-1] (LSB first).
  - On fe n=9: data_oe = ~parity.
  - On fe n=10: data_oe = 0 (stop bit; line released).
  - On fe n=11: sample synced data. Data 0: pulse tx_done. Data 1: pulse tx_error with err_code=10. Either way go to IDLE.
- Timeout counter: reset on entry to XFER and on every fe. If it reaches TIMEOUT_CYCLES:
  - release both lines in that cycle;
  - pulse tx_error with err_code=01;
  - go to IDLE.
  - If timeout and fe occur in the same cycle, the fe wins.
- IDLE: both oe=0 and busy=0. tx_done/tx_error pulse in the first cycle back in IDLE, together with busy falling. A new accept is possible that same cycle.
- Device clock activity outside XFER is ignored and never moves the state.
- Reset mid-transfer releases both lines immediately and produces no done/error pulse.

Test Plan (bench: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=500; device model clocks at a 40-cycle period, changes data on clock-high):
- Send 0xED with device ACK → clk_oe high exactly 21 cycles (20 + 1 REQ). Device samples on rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done=1 for 1 cycle; err_code stays 00.
- Send 0x01 and then 0x00 back-to-back, reasserting tx_valid on the tx_done cycle → parity bits 0 then 1. Second transfer accepted in the tx_done cycle; two tx_done pulses.
- Device omits ACK (data high on edge 11) → tx_error 1 cycle, err_code=10, both oe=0, tx_ready=1.
- Device never clocks after REQ → tx_error at cycle 500 of XFER, err_code=01, lines released.
- Device stops after 5 edges → timeout error 01 exactly 500 cycles after the 5th fe.
- reset_btn asserted mid-XFER (edge 4) → clk_oe=data_oe=0 asynchronously; no tx_done/tx_error; busy=0. Next request starts with a full INHIBIT.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with request-to-send, ACK check and timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk_in,
    input  logic       reset_btn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, INHIBIT, REQ, XFER} state_t;
    state_t state;
    logic [1:0] clk_sync, data_sync;
    logic clk_prev, fe_q, fe;
    logic [8:0] shreg;
    logic [3:0] n, n_next;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    assign fe = clk_prev & ~clk_sync[1];
    assign n_next = n + 4'd1;
    // Lines idle high, so the synchronisers reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            clk_sync <= 2'b11;
            data_sync <= 2'b11;
            clk_prev <= 1'b1;
            fe_q <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev <= clk_sync[1];
            fe_q <= fe;
        end
    end
    always_ff @(posedge clk_in or posedge reset_btn) begin
        if (reset_btn) begin
            state <= IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy <= 1'b0;
            tx_ready <= 1'b1;
            tx_done <= 1'b0;
            tx_error <= 1'b0;
            err_code <= 2'b00;
            shreg <= '0;
            n <= '0;
            icnt <= '0;
            tcnt <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: if (tx_valid && tx_ready) begin
                    shreg <= {~^tx_data, tx_data};
                    state <= INHIBIT;
                    ps2_clk_oe <= 1'b1;
                    ps2_data_oe <= 1'b0;
                    busy <= 1'b1;
                    tx_ready <= 1'b0;
                    err_code <= 2'b00;
                    icnt <= '0;
                end
                INHIBIT: if (icnt == I_LAST) begin
                    state <= REQ;
                    ps2_data_oe <= 1'b1;
                end else begin
                    icnt <= icnt + 1'b1;
                end
                REQ: begin
                    state <= XFER;
                    ps2_clk_oe <= 1'b0;
                    n <= '0;
                    tcnt <= '0;
                end
                XFER: if (fe_q) begin
                    n <= n_next;
                    tcnt <= '0;
                    if (n_next <= 4'd9) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg <= {1'b0, shreg[8:1]};
                    end else if (n_next == 4'd10) begin
                        ps2_data_oe <= 1'b0;
                    end else begin
                        // Edge 11: device ACK is a low data line.
                        state <= IDLE;
                        ps2_data_oe <= 1'b0;
                        busy <= 1'b0;
                        tx_ready <= 1'b1;
                        tx_done <= ~data_sync[1];
                        tx_error <= data_sync[1];
                        if (data_sync[1]) err_code <= 2'b10;
                    end
                end else if (tcnt == T_LAST) begin
                    state <= IDLE;
                    ps2_clk_oe <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy <= 1'b0;
                    tx_ready <= 1'b1;
                    tx_error <= 1'b1;
                    err_code <= 2'b01;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and randomized checks of ps2_host_tx against a behavioural PS/2 device and frame model.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 500;
    localparam int FE_LAT = 4;
    logic clk_in = 0, reset_btn = 1, tx_valid = 0;
    logic [7:0] tx_data = '0;
    logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic dev_clk_low = 0, dev_data_low = 0;
    logic ps2_clk_i, ps2_data_i;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, oe_run = 0, last_run = 0;
    int exp_done = 0, exp_err = 0;
    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);
    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk_in), .reset_btn(reset_btn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .tx_done(tx_done), .tx_error(tx_error), .err_code(err_code)
    );
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(negedge clk_in) begin
        if (tx_done) done_cnt++;
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (ps2_clk_oe) oe_run++;
        else if (oe_run != 0) begin
            last_run = oe_run;
            oe_run = 0;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Wire frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction
    task automatic send(input logic [7:0] b);
        @(negedge clk_in);
        tx_valid = 1;
        tx_data = b;
        @(negedge clk_in);
        tx_valid = 0;
        check("accept_busy", busy, 1);
        check("accept_ready", tx_ready, 0);
    endtask
    task automatic wait_release(output int t0);
        int t = 0;
        while (!ps2_clk_oe && t < 100) begin @(negedge clk_in); t++; end
        while (ps2_clk_oe && t < 200) begin @(negedge clk_in); t++; end
        t0 = cyc;
        check("release_seen", t < 200, 1);
    endtask
    task automatic device_xfer(input int edges, input bit ack, output logic [10:0] fr, output int fall_cyc);
        int t0;
        fr = '0;
        fall_cyc = 0;
        wait_release(t0);
        repeat ($urandom_range(5, 30)) @(negedge clk_in);
        fr[0] = ps2_data_i;
        for (int k = 1; k <= edges; k++) begin
            if (k == 11) begin
                dev_data_low = ack;
                repeat (5) @(negedge clk_in);
            end
            dev_clk_low = 1;
            fall_cyc = cyc;
            repeat (k == 11 ? 10 : 20) @(negedge clk_in);
            dev_clk_low = 0;
            if (k <= 10) fr[k] = ps2_data_i;
            dev_data_low = 0;
            if (k < 11) repeat (20) @(negedge clk_in);
        end
    endtask
    task automatic wait_err(input int budget);
        int t = 0;
        int e0 = err_cnt;
        while (err_cnt == e0 && t < budget) begin @(negedge clk_in); t++; end
        check("err_within_budget", t < budget, 1);
        @(negedge clk_in);
    endtask
    task automatic good_xfer(input string tag, input logic [7:0] b);
        logic [10:0] fr;
        int fc;
        send(b);
        device_xfer(11, 1, fr, fc);
        check({tag, "_clk_oe_len"}, last_run, INH + 1);
        check({tag, "_frame"}, fr, frame_of(b));
        repeat (3) @(negedge clk_in);
        exp_done++;
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_err_code"}, err_code, 2'b00);
        check({tag, "_busy_low"}, busy, 0);
    endtask
    initial begin
        logic [10:0] fr1, fr2;
        logic [7:0] b;
        int fc, t0, t;
        repeat (3) @(negedge clk_in);
        reset_btn = 0;
        @(negedge clk_in);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_err_code", err_code, 2'b00);
        good_xfer("ed", 8'hED);
        // Back-to-back: second request raised in the tx_done cycle.
        send(8'h01);
        fork
            device_xfer(11, 1, fr1, fc);
            begin
                t = 0;
                while (!tx_done && t < 1000) begin @(negedge clk_in); t++; end
                check("b2b_done_seen", t < 1000, 1);
                tx_valid = 1;
                tx_data = 8'h00;
                @(negedge clk_in);
                tx_valid = 0;
                check("b2b_second_accept", tx_ready, 0);
            end
        join
        check("b2b_frame1", fr1, frame_of(8'h01));
        check("b2b_parity1", fr1[9], 0);
        device_xfer(11, 1, fr2, fc);
        check("b2b_clk_oe_len2", last_run, INH + 1);
        check("b2b_frame2", fr2, frame_of(8'h00));
        check("b2b_parity2", fr2[9], 1);
        repeat (3) @(negedge clk_in);
        exp_done += 2;
        check("b2b_done_cnt", done_cnt, exp_done);
        b = 8'($urandom);
        send(b);
        device_xfer(11, 0, fr1, fc);
        repeat (3) @(negedge clk_in);
        exp_err++;
        check("nak_frame", fr1, frame_of(b));
        check("nak_err_cnt", err_cnt, exp_err);
        check("nak_err_code", err_code, 2'b10);
        check("nak_clk_oe", ps2_clk_oe, 0);
        check("nak_data_oe", ps2_data_oe, 0);
        check("nak_ready", tx_ready, 1);
        check("nak_done_cnt", done_cnt, exp_done);
        send(8'($urandom));
        wait_release(t0);
        check("noclk_start_bit", ps2_data_oe, 1);
        wait_err(TMO + 50);
        exp_err++;
        check("noclk_latency", err_cyc - t0, TMO);
        check("noclk_err_cnt", err_cnt, exp_err);
        check("noclk_err_code", err_code, 2'b01);
        check("noclk_clk_oe", ps2_clk_oe, 0);
        check("noclk_data_oe", ps2_data_oe, 0);
        send(8'($urandom));
        device_xfer(5, 1, fr1, fc);
        wait_err(TMO + 50);
        exp_err++;
        check("stall5_latency", err_cyc - fc, FE_LAT + TMO);
        check("stall5_err_cnt", err_cnt, exp_err);
        check("stall5_err_code", err_code, 2'b01);
        check("stall5_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        b = 8'($urandom) & 8'hF7;
        send(b);
        device_xfer(4, 1, fr1, fc);
        check("rstmid_data_oe_before", ps2_data_oe, 1);
        #2 reset_btn = 1;
        #1;
        check("rstmid_clk_oe", ps2_clk_oe, 0);
        check("rstmid_data_oe", ps2_data_oe, 0);
        check("rstmid_busy", busy, 0);
        @(negedge clk_in);
        reset_btn = 0;
        repeat (TMO + 100) @(negedge clk_in);
        check("rstmid_no_done", done_cnt, exp_done);
        check("rstmid_no_err", err_cnt, exp_err);
        check("rstmid_ready", tx_ready, 1);
        good_xfer("post_rst", 8'($urandom));
        for (int i = 0; i < 3; i++) good_xfer("rand", 8'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
